// File: rtl/cpu_exec_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cpu_exec_scheduler
// Purpose  : Sole source of the CPU core's one-cycle execute strobe. Supports
//            halt, free-run at a slow or turbo rate, push-button single-step
//            and a hardware breakpoint on the instruction pointer.
// Options  : STEP_DEBOUNCE_EN - when defined, the synchronized step button
//            must stay high for DEBOUNCE_CYCLES consecutive cycles before a
//            single step event fires (one event per press).
// Revision : 1.0 - initial release
// ============================================================================
module cpu_exec_scheduler #(
  parameter int unsigned SLOW_DIV        = 12_500_000,
  parameter int unsigned TURBO_DIV       = 2,
  parameter int unsigned DIV_WIDTH       = 24,
  parameter int unsigned DEBOUNCE_CYCLES = 250_000
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        run_sw_i,
  input  logic        turbo_sw_i,
  input  logic        step_btn_i,
  input  logic [7:0]  instruction_pointer_i,
  input  logic [7:0]  breakpoint_i,
  input  logic        bp_valid_i,
  output logic        enable_o,
  output logic [1:0]  state_o,
  output logic [15:0] cycle_count_o
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_e;

  // Terminal counts of the rate divider (count runs 0..DIV-1).
  localparam logic [DIV_WIDTH-1:0] C_SLOW_MAX  = DIV_WIDTH'(SLOW_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] C_TURBO_MAX = DIV_WIDTH'(TURBO_DIV - 1);

  // Reject parameter sets that would break the one-cycle enable guarantee.
  if (SLOW_DIV < 2 || TURBO_DIV < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("cpu_exec_scheduler: illegal divider or debounce parameter");
  end

  // --------------------------------------------------------------------------
  // Input synchronizers, bit order {step, turbo, run}
  // --------------------------------------------------------------------------
  logic [2:0] sync_meta_q;
  logic [2:0] sync_q;
  logic       w_run;
  logic       w_turbo;
  logic       w_step;
  logic       w_step_evt;

  // Two-flop synchronizer for the three asynchronous board inputs.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= {step_btn_i, turbo_sw_i, run_sw_i};
      sync_q      <= sync_meta_q;
    end
  end

  assign w_run   = sync_q[0];
  assign w_turbo = sync_q[1];
  assign w_step  = sync_q[2];

  // --------------------------------------------------------------------------
  // Step event generation
  // --------------------------------------------------------------------------
`ifdef STEP_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] C_DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            db_fired_q;
  logic            db_fired_d;

  // Count consecutive high samples; fire once per press, re-arm on a low.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_fired_d = db_fired_q;
    w_step_evt = 1'b0;
    if (!w_step) begin
      db_cnt_d   = '0;
      db_fired_d = 1'b0;
    end else if (!db_fired_q) begin
      if (db_cnt_q == C_DB_LAST) begin
        w_step_evt = 1'b1;
        db_fired_d = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Debounce counter and fired flag.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      db_cnt_q   <= '0;
      db_fired_q <= 1'b0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      db_fired_q <= db_fired_d;
    end
  end
`else
  logic step_prev_q;

  // Previous synchronized step level for rising-edge detection.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      step_prev_q <= 1'b0;
    end else begin
      step_prev_q <= w_step;
    end
  end

  assign w_step_evt = w_step & ~step_prev_q;
`endif

  // --------------------------------------------------------------------------
  // Scheduler FSM, rate divider, breakpoint arming, pulse counter
  // --------------------------------------------------------------------------
  state_e                 state_q;
  state_e                 state_d;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   div_d;
  logic                   bp_armed_q;
  logic                   bp_armed_d;
  logic                   enable_q;
  logic                   enable_d;
  logic [15:0]            cycle_count_q;
  logic [15:0]            cycle_count_d;
  logic [DIV_WIDTH-1:0]   w_div_max;
  logic                   w_tick;
  logic                   w_ip_hit;

  assign w_div_max = w_turbo ? C_TURBO_MAX : C_SLOW_MAX;
  // >= so that a mid-count switch to turbo ticks on the very next cycle.
  assign w_tick    = (div_q >= w_div_max);
  assign w_ip_hit  = (instruction_pointer_i == breakpoint_i);

  // Next-state, divider, breakpoint-arm and strobe decode.
  always_comb begin
    state_d    = state_q;
    div_d      = '0;
    enable_d   = 1'b0;
    bp_armed_d = bp_armed_q;
    // Leaving the breakpoint address re-arms the breakpoint.
    if (!w_ip_hit) begin
      bp_armed_d = 1'b1;
    end
    case (state_q)
      ST_HALT: begin
        if (w_run) begin
          state_d = ST_RUN;
        end else if (w_step_evt) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (!w_run) begin
          state_d = ST_HALT;
        end else if (w_tick) begin
          if (bp_valid_i && bp_armed_q && w_ip_hit) begin
            state_d    = ST_BREAK;
            bp_armed_d = 1'b0;
          end else begin
            enable_d = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_WIDTH'(1);
        end
      end
      ST_STEP: begin
        enable_d = 1'b1;
        state_d  = ST_HALT;
      end
      ST_BREAK: begin
        if (!w_run) begin
          state_d = ST_HALT;
        end else if (w_step_evt) begin
          state_d = ST_STEP;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
    cycle_count_d = cycle_count_q + 16'(enable_d);
  end

  // State, divider, arm flag, strobe and pulse-count registers.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q       <= ST_HALT;
      div_q         <= '0;
      bp_armed_q    <= 1'b1;
      enable_q      <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bp_armed_q    <= bp_armed_d;
      enable_q      <= enable_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign enable_o      = enable_q;
  assign state_o       = state_q;
  assign cycle_count_o = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_exec_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_exec_scheduler
// Purpose  : Self-checking bench for cpu_exec_scheduler with a behavioural
//            reference model (SLOW_DIV=8, TURBO_DIV=2). A second instance
//            with TURBO_DIV=1 exercises the 16-bit pulse counter wrap.
//            Build with STEP_DEBOUNCE_EN to exercise the debounce option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_exec_scheduler;

  localparam int P_SLOW  = 8;
  localparam int P_TURBO = 2;
`ifdef STEP_DEBOUNCE_EN
  localparam int P_DB = 4;
`else
  localparam int P_DB = 1;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        run_sw = 1'b0;
  logic        turbo_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic [7:0]  ip = 8'h00;
  logic        ip_clr = 1'b1;
  logic [7:0]  bp = 8'h00;
  logic        bp_valid = 1'b0;
  logic        enable_o;
  logic [1:0]  state_o;
  logic [15:0] cycle_count_o;

  logic        w_resetn = 1'b0;
  logic        w_run = 1'b0;
  logic        w_turbo = 1'b0;
  logic        w_enable;
  logic [1:0]  w_state;
  logic [15:0] w_count;

  int n_total = 0;
  int n_bad = 0;
  int n_pulses = 0;

  always #5 clk = ~clk;

  cpu_exec_scheduler #(
    .SLOW_DIV(P_SLOW), .TURBO_DIV(P_TURBO), .DIV_WIDTH(4), .DEBOUNCE_CYCLES(4)
  ) u_dut (
    .clk_i(clk), .resetn_i(resetn), .run_sw_i(run_sw), .turbo_sw_i(turbo_sw),
    .step_btn_i(step_btn), .instruction_pointer_i(ip), .breakpoint_i(bp),
    .bp_valid_i(bp_valid), .enable_o(enable_o), .state_o(state_o),
    .cycle_count_o(cycle_count_o)
  );

  cpu_exec_scheduler #(
    .SLOW_DIV(2), .TURBO_DIV(1), .DIV_WIDTH(2), .DEBOUNCE_CYCLES(4)
  ) u_wrap (
    .clk_i(clk), .resetn_i(w_resetn), .run_sw_i(w_run), .turbo_sw_i(w_turbo),
    .step_btn_i(1'b0), .instruction_pointer_i(8'h00), .breakpoint_i(8'h00),
    .bp_valid_i(1'b0), .enable_o(w_enable), .state_o(w_state),
    .cycle_count_o(w_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // The "core": IP advances on the edge after each enable.
  always @(posedge clk) begin
    if (ip_clr) ip <= 8'h00;
    else if (enable_o) ip <= ip + 8'h01;
  end

  // ---------------- behavioural reference model ----------------
  // Inputs are seen two edges late; a step event is the moment the
  // synchronized button has been high for exactly P_DB cycles.
  logic [1:0]  m_state;
  logic        m_en;
  logic [15:0] m_cnt;
  logic        m_armed;
  int          m_elapsed;
  int          m_step_run;
  logic [1:0]  h_run, h_turbo, h_step;

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_state = 2'd0; m_en = 1'b0; m_cnt = 16'h0; m_armed = 1'b1;
        m_elapsed = 0; m_step_run = 0;
        h_run = 2'b00; h_turbo = 2'b00; h_step = 2'b00;
      end else begin
        logic s_run, evt;
        int div;
        s_run = h_run[1];
        evt   = (m_step_run == P_DB);
        div   = h_turbo[1] ? P_TURBO : P_SLOW;
        m_en  = 1'b0;
        if (ip != bp) m_armed = 1'b1;
        case (m_state)
          2'd0: begin
            if (s_run) begin m_state = 2'd1; m_elapsed = 0; end
            else if (evt) m_state = 2'd2;
          end
          2'd1: begin
            if (!s_run) m_state = 2'd0;
            else if (m_elapsed >= div - 1) begin
              m_elapsed = 0;
              if (bp_valid && m_armed && ip == bp) begin
                m_state = 2'd3; m_armed = 1'b0;
              end else m_en = 1'b1;
            end else m_elapsed++;
          end
          2'd2: begin m_en = 1'b1; m_state = 2'd0; end
          default: begin
            if (!s_run) m_state = 2'd0;
            else if (evt) m_state = 2'd2;
          end
        endcase
        m_cnt = m_cnt + {15'h0, m_en};
        m_step_run = h_step[0] ? ((m_step_run < 1000) ? m_step_run + 1 : m_step_run) : 0;
        h_run   = {h_run[0], run_sw};
        h_turbo = {h_turbo[0], turbo_sw};
        h_step  = {h_step[0], step_btn};
      end
    end
  end

  // Every cycle: DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    check("enable", 32'(enable_o), 32'(m_en));
    check("state", 32'(state_o), 32'(m_state));
    check("count", 32'(cycle_count_o), 32'(m_cnt));
    if (enable_o) n_pulses++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    int wn;
    logic hit;

    // Reset and idle
    cyc(3);
    resetn = 1'b1; w_resetn = 1'b1; ip_clr = 1'b0;
    cyc(20);
    check("idle_state", 32'(state_o), 32'd0);
    check("idle_count", 32'(cycle_count_o), 32'd0);

    // Slow run: RUN three edges after the switch, first pulse 8 later -> 9 in 80
    p0 = n_pulses;
    run_sw = 1'b1;
    cyc(80);
    check("slow_pulses", 32'(n_pulses - p0), 32'd9);
    // Turbo mid-count: pulses at edges 83,85..119 of the window -> 19
    p0 = n_pulses;
    turbo_sw = 1'b1;
    cyc(40);
    check("turbo_pulses", 32'(n_pulses - p0), 32'd19);
    check("pulse_total", 32'(cycle_count_o), 32'(n_pulses));

    // Single step
    run_sw = 1'b0; turbo_sw = 1'b0;
    cyc(10);
    check("halted", 32'(state_o), 32'd0);
`ifndef STEP_DEBOUNCE_EN
    step_btn = 1'b1;
    cyc(1);
    step_btn = 1'b0;
    cyc(2);
    check("step_state", 32'(state_o), 32'd2);
    cyc(1);
    check("step_enable", 32'(enable_o), 32'd1);
    check("step_back_halt", 32'(state_o), 32'd0);
    cyc(5);
`endif
    p0 = n_pulses;
    step_btn = 1'b1;
    cyc(50);
    step_btn = 1'b0;
    cyc(10);
    check("step_hold_pulses", 32'(n_pulses - p0), 32'd1);

    // Breakpoint at 0x05 running from IP 0
    ip_clr = 1'b1; cyc(1); ip_clr = 1'b0;
    bp = 8'h05; bp_valid = 1'b1;
    p0 = n_pulses;
    run_sw = 1'b1;
    for (int i = 0; i < 200 && state_o != 2'd3; i++) cyc(1);
    check("bp_state", 32'(state_o), 32'd3);
    check("bp_pulses", 32'(n_pulses - p0), 32'd5);
    check("bp_ip", 32'(ip), 32'h05);
    run_sw = 1'b0;
    cyc(5);
    check("bp_to_halt", 32'(state_o), 32'd0);
    run_sw = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      cyc(1);
      hit = enable_o;
    end
    check("resume_enable", 32'(enable_o), 32'd1);
    check("resume_ip", 32'(ip), 32'h05);
    check("resume_state", 32'(state_o), 32'd1);
    run_sw = 1'b0; bp_valid = 1'b0;
    cyc(5);

    // Randomized mixture of all controls
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 29) == 0) turbo_sw = ~turbo_sw;
      if ($urandom_range(0, 14) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 49) == 0) bp_valid = ~bp_valid;
      if ($urandom_range(0, 39) == 0) bp = 8'($urandom_range(0, 15));
      ip_clr = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    ip_clr = 1'b0; step_btn = 1'b0; bp_valid = 1'b0;
    run_sw = 1'b0;
    cyc(6);

`ifdef STEP_DEBOUNCE_EN
    // Debounce: 3-cycle glitch ignored, 6-cycle press gives one step
    p0 = n_pulses;
    step_btn = 1'b1; cyc(3); step_btn = 1'b0; cyc(15);
    check("db_glitch", 32'(n_pulses - p0), 32'd0);
    step_btn = 1'b1; cyc(6); step_btn = 1'b0; cyc(15);
    check("db_press", 32'(n_pulses - p0), 32'd1);
`endif

    // Asynchronous reset while running
    run_sw = 1'b1; turbo_sw = 1'b1;
    cyc(10);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = enable_o;
    end
    #2;
    resetn = 1'b0;
    #1;
    check("arst_enable", 32'(enable_o), 32'd0);
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_count", 32'(cycle_count_o), 32'd0);
    run_sw = 1'b0; turbo_sw = 1'b0;
    cyc(2);
    resetn = 1'b1;
    cyc(3);

    // Pulse counter wrap on the TURBO_DIV=1 instance
    check("wrap_start", 32'(w_count), 32'd0);
    w_run = 1'b1; w_turbo = 1'b1;
    wn = 0;
    for (int i = 0; i < 70000 && wn < 65536; i++) begin
      @(negedge clk);
      if (w_enable) begin
        wn++;
        if (wn == 65535) check("wrap_ffff", 32'(w_count), 32'hFFFF);
        if (wn == 65536) check("wrap_zero", 32'(w_count), 32'h0000);
      end
    end
    check("wrap_pulses", 32'(wn), 32'd65536);
    check("wrap_state", 32'(w_state), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
